// File: rtl/sequential_multiplier.sv
// Shift-add multiplier rebuilding full-scale magnitude: product_out = (fraction * scale) >> FRAC.
// One fraction bit per clock, restarted by every sample_now strobe.
module sequential_multiplier #(
  parameter int unsigned WIDTH         = 18,
  parameter int unsigned FRAC          = 8,
  parameter bit          SAT_FF_AS_ONE = 1'b1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             sample_now,
  input  logic [WIDTH-1:0] scale,
  input  logic [FRAC-1:0]  fraction,
  output logic [WIDTH-1:0] product_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned AW = WIDTH + FRAC;
  localparam int unsigned IW = (FRAC > 1) ? $clog2(FRAC) : 1;
  localparam int unsigned CW = IW + 1;
  localparam logic [CW-1:0] LAST = CW'(FRAC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [FRAC-1:0]  f_q, f_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic             done_q, done_d;
  logic [AW-1:0]    addend;
  logic             sat_one;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      f_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      f_q     <= f_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    addend  = f_q[count_q[IW-1:0]] ? (AW'(m_q) << count_q) : '0;
    sat_one = SAT_FF_AS_ONE && (&f_q);
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    f_d     = f_q;
    acc_d   = acc_q;
    count_d = count_q;
    prod_d  = prod_q;
    done_d  = 1'b0;
    // A strobe in any state restarts; this also suppresses a pending DONE update.
    if (sample_now) begin
      state_d = S_BUSY;
      m_d     = scale;
      f_d     = fraction;
      acc_d   = '0;
      count_d = '0;
    end else begin
      case (state_q)
        S_BUSY: begin
          acc_d   = acc_q + addend;
          count_d = count_q + CW'(1);
          if (count_q == LAST) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          prod_d  = sat_one ? m_q : acc_q[AW-1:FRAC];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
        end
      endcase
    end
  end

  assign product_out = prod_q;
  assign done        = done_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_sequential_multiplier.sv
// Directed-vector bench for sequential_multiplier; a second instance has the all-ones clamp disabled.
module tb_sequential_multiplier;

  logic        clk = 1'b0;
  logic        nrst;
  logic        sample_now;
  logic [17:0] scale;
  logic [7:0]  fraction;
  logic [17:0] product_out, product_out0;
  logic        busy, busy0;
  logic        done, done0;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [17:0] model_prod  = '0;
  logic [17:0] model_prod0 = '0;

  always #5 clk = ~clk;

  sequential_multiplier dut (
    .clk(clk), .nrst(nrst), .sample_now(sample_now), .scale(scale),
    .fraction(fraction), .product_out(product_out), .busy(busy), .done(done)
  );

  sequential_multiplier #(.SAT_FF_AS_ONE(1'b0)) dut0 (
    .clk(clk), .nrst(nrst), .sample_now(sample_now), .scale(scale),
    .fraction(fraction), .product_out(product_out0), .busy(busy0), .done(done0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string nm);
    n_cmp++;
    if ({product_out, busy, done} !== {model_prod, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL %s: prod=%0d busy=%b done=%b, required prod=%0d busy=0 done=0",
               nm, product_out, busy, done, model_prod);
    end
  endtask

  // Called right after the E0 edge: checks the busy window, then the done cycle.
  task automatic finish_op(input logic [17:0] exp, input logic [17:0] exp0, input string nm);
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if ({busy, done, product_out, product_out0} !== {1'b1, 1'b0, model_prod, model_prod0}) begin
        n_err++;
        $display("FAIL %s busy-window cycle %0d: busy=%b done=%b prod=%0d/%0d, required busy=1 done=0 prod=%0d/%0d",
                 nm, i, busy, done, product_out, product_out0, model_prod, model_prod0);
      end
      tick();
    end
    model_prod  = exp;
    model_prod0 = exp0;
    n_cmp++;
    if ({busy, done, done0, product_out, product_out0} !== {1'b0, 1'b1, 1'b1, exp, exp0}) begin
      n_err++;
      $display("FAIL %s result: busy=%b done=%b/%b prod=%0d/%0d, required busy=0 done=1/1 prod=%0d/%0d",
               nm, busy, done, done0, product_out, product_out0, exp, exp0);
    end
    tick();
    n_cmp++;
    if ({done, product_out} !== {1'b0, exp}) begin
      n_err++;
      $display("FAIL %s done-pulse-width: done=%b prod=%0d, required done=0 prod=%0d",
               nm, done, product_out, exp);
    end
  endtask

  task automatic strobe(input logic [17:0] s, input logic [7:0] f);
    sample_now = 1'b1;
    scale      = s;
    fraction   = f;
    tick();
    sample_now = 1'b0;
    scale      = 18'($urandom);
    fraction   = 8'($urandom);
  endtask

  task automatic run_op(input logic [17:0] s, input logic [7:0] f,
                        input logic [17:0] exp, input logic [17:0] exp0, input string nm);
    strobe(s, f);
    finish_op(exp, exp0, nm);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    sample_now = 1'b0;
    scale = '0;
    fraction = '0;
    tick();
    tick();
    nrst = 1'b1;
    model_prod  = '0;
    model_prod0 = '0;
    check_idle_outputs("reset");
    tick();
    check_idle_outputs("after_reset_release");
  endtask

  task automatic test_basic();
    run_op(18'd1000,    8'h80, 18'd500,  18'd500,  "half");
    run_op(18'd1000,    8'hC0, 18'd750,  18'd750,  "three_quarter");
    run_op(18'h3FFFF,   8'h01, 18'd1023, 18'd1023, "trunc_lsb");
    run_op(18'd1000,    8'h00, 18'd0,    18'd0,    "frac_zero");
    run_op(18'd0,       8'hA5, 18'd0,    18'd0,    "scale_zero");
  endtask

  task automatic test_saturate();
    run_op(18'h3FFFF, 8'hFF, 18'h3FFFF, 18'd261119, "sat_max");
    run_op(18'd1000,  8'hFF, 18'd1000,  18'd996,    "sat_ff");
  endtask

  task automatic test_restart();
    strobe(18'd1000, 8'h80);
    for (int i = 0; i < 3; i++) tick();
    strobe(18'd1000, 8'h40);
    finish_op(18'd250, 18'd250, "restart_busy");
  endtask

  task automatic test_restart_at_done();
    strobe(18'd1000, 8'hC0);
    for (int i = 0; i < 8; i++) tick();
    strobe(18'd1000, 8'h80);
    finish_op(18'd500, 18'd500, "restart_at_done");
  endtask

  task automatic test_held_strobe();
    sample_now = 1'b1;
    scale      = 18'd2000;
    fraction   = 8'h40;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_cmp++;
      if ({busy, done, product_out} !== {1'b1, 1'b0, model_prod}) begin
        n_err++;
        $display("FAIL held_strobe cycle %0d: busy=%b done=%b prod=%0d, required busy=1 done=0 prod=%0d",
                 i, busy, done, product_out, model_prod);
      end
    end
    sample_now = 1'b0;
    finish_op(18'd500, 18'd500, "held_strobe_release");
  endtask

  task automatic test_reset_mid();
    strobe(18'd1000, 8'h80);
    for (int i = 0; i < 4; i++) tick();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    model_prod  = '0;
    model_prod0 = '0;
    check_idle_outputs("reset_mid_op");
    for (int i = 0; i < 12; i++) begin
      tick();
      check_idle_outputs("reset_mid_quiet");
    end
    run_op(18'd1000, 8'hC0, 18'd750, 18'd750, "after_reset_op");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_restart();
    test_restart_at_done();
    test_held_strobe();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sequential_multiplier.md
Name: sequential_multiplier

Overview:
- Inverse of the synthesizer's sequential divider. It takes an 8-bit normalized fraction (quotient × 256) and an 18-bit scale value, and rebuilds the full-scale magnitude as (fraction × scale) >> 8.
- Uses a multi-cycle shift-add, one fraction bit per clock, triggered by the same sample_now strobe that drives the divider.
- Sits between the normalized-sample path and the amplitude/oscillator-domain logic.

Parameters:
- WIDTH, 18, width of the scale operand and of product_out.
- FRAC, 8, width of the fraction operand; also the right-shift applied to the raw product.
- SAT_FF_AS_ONE, 1, when 1 an all-ones fraction means exactly 1.0 (mirrors the divider's 0x100→0xFF clamp).

Ports:
- clk  input  1  system clock, all state on rising edge.
- nrst  input  1  synchronous active-low reset, sampled on rising edge of clk.
- sample_now  input  1  start strobe; operands captured on the edge where it is high.
- scale  input  WIDTH  multiplicand (unsigned).
- fraction  input  FRAC  multiplier (unsigned, value/256).
- product_out  output  WIDTH  registered result, held between updates.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse, high in the cycle product_out first shows a new value.

Behaviour:
- Reset (nrst low at an edge): state=IDLE, product_out=0, busy=0, done=0, internal accumulator/count/operand registers=0. Reset mid-operation aborts the operation with no output update.
- States: IDLE, BUSY, DONE.
- IDLE→BUSY on an edge with sample_now=1. At that edge (E0):
  - latch m=scale, f=fraction;
  - clear acc (WIDTH+FRAC bits) and count (log2(FRAC)+1 bits).
- BUSY, edges E1..E8 (FRAC edges):
  - acc <= acc + (f[count] ? m << count : 0);
  - count <= count+1;
  - after the edge with count==FRAC-1, go to DONE.
- DONE, edge E9 (FRAC+1 edges after E0):
  - product_out <= acc[WIDTH+FRAC-1:FRAC] (truncation, no rounding);
  - if SAT_FF_AS_ONE=1 and f is all ones, product_out <= m instead;
  - done registered high for exactly the cycle after E9;
  - state → IDLE.
- busy: high in every cycle where state is BUSY or DONE; low in IDLE.
- Latency: fixed FRAC+1 clocks from the sample_now edge to product_out/done update.
- Width: acc never overflows, since max product is (2^WIDTH-1)(2^FRAC-1) < 2^(WIDTH+FRAC). Result ≤ scale, so product_out never exceeds WIDTH bits.
- sample_now while BUSY or DONE:
  - restart from E0 with the new operands; the old operation is discarded;
  - product_out keeps its previous value and done does not pulse for the discarded operation.
- sample_now in the same edge as the DONE transition: the restart wins and no output update occurs.
- Operands may change freely after E0; only the latched copies are used.
- sample_now held high continuously: restarts every edge, so product_out never updates.
- fraction=0 or scale=0: normal timing, result 0, done still pulses.

Test Plan:
- Reset: hold nrst=0 for 2 edges, release → product_out=0, busy=0, done=0.
- scale=1000, fraction=0x80, 1-cycle sample_now → busy high 9 cycles; done pulses 9 clocks after strobe edge; product_out=500.
- scale=1000, fraction=0xC0 → 750. scale=0x3FFFF, fraction=0x01 → 1023 (truncated). fraction=0x00 → 0 with done pulse.
- SAT_FF_AS_ONE=1, scale=1000, fraction=0xFF → 1000. With SAT_FF_AS_ONE=0, same stimulus → 996.
- Start scale=1000/fraction=0x80, re-strobe 4 clocks later with fraction=0x40 → no done for the first; a single done 9 clocks after the second strobe; product_out=250; prior value held until then.
- Pull nrst low at cycle 5 of an operation → product_out=0, busy=0, no done pulse. A fresh strobe afterwards completes normally.
